ct_ciu_l2of_int_ctrl: RTL

CT_CIU_L2OF_INT_CTRL -- requirements
Module: ct_ciu_l2of_int_ctrl

---
 rtl/ct_ciu_regs_pkg.sv | 26 ++
 rtl/ct_ciu_l2of_int_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ct_ciu_regs_pkg.sv
// Shared CSR definitions for the CIU L2 overflow interrupt controller: FSM encoding and L2IE layout.
// Optional macro CIU_L2OF_INT_THROTTLE_EN adds the GAP throttle state.
package ct_ciu_regs_pkg;

    localparam logic [3:0] L2IE_IDX     = 4'hd;
    localparam int         L2IE_EN_LSB  = 0;
    localparam int         L2IE_EN_W    = 4;
    localparam int         L2IE_GAP_LSB = 8;
    localparam int         L2IE_GAP_W   = 8;

`ifdef CIU_L2OF_INT_THROTTLE_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_CLR = 2'd2,
        ST_GAP      = 2'd3
    } l2of_int_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_CLR = 2'd2
    } l2of_int_state_e;
`endif

endpackage

// File: rtl/ct_ciu_l2of_int_ctrl.sv
// L2 overflow interrupt controller: L2IE enable register plus level request/ack handshake FSM.
// Optional macro CIU_L2OF_INT_THROTTLE_EN adds a programmable post-clear GAP before re-arming.
module ct_ciu_l2of_int_ctrl
    import ct_ciu_regs_pkg::*;
(
    input  logic        smpr_clk,
    input  logic        x_fifo_rst_b,
    input  logic [3:0]  x_l2of_int,
    input  logic        regs_sel_final_x,
    input  logic        regs_wen,
    input  logic [3:0]  regs_idx,
    input  logic [63:0] regs_wdata_final,
    output logic [63:0] x_ie_value,
    output logic        int_req,
    input  logic        int_ack,
    output logic [3:0]  int_src
);

    l2of_int_state_e state, state_nxt;
    logic [3:0]      ie_mask;
    logic [3:0]      masked;
    logic [3:0]      src_nxt;
    logic            ie_wen;
    logic            unused_wdata;

    assign ie_wen = regs_sel_final_x & regs_wen & (regs_idx == L2IE_IDX);
    assign masked = x_l2of_int & ie_mask;

    always_ff @(posedge smpr_clk or negedge x_fifo_rst_b) begin
        if (!x_fifo_rst_b)
            ie_mask <= '0;
        else if (ie_wen)
            ie_mask <= regs_wdata_final[L2IE_EN_LSB +: L2IE_EN_W];
    end

`ifdef CIU_L2OF_INT_THROTTLE_EN
    logic [7:0] ie_gap;
    logic [7:0] gap_cnt;

    always_ff @(posedge smpr_clk or negedge x_fifo_rst_b) begin
        if (!x_fifo_rst_b)
            ie_gap <= '0;
        else if (ie_wen)
            ie_gap <= regs_wdata_final[L2IE_GAP_LSB +: L2IE_GAP_W];
    end

    // Loaded on entry so GAP lasts exactly ie_gap cycles; exit fires at count 1.
    always_ff @(posedge smpr_clk or negedge x_fifo_rst_b) begin
        if (!x_fifo_rst_b)
            gap_cnt <= '0;
        else if (state == ST_WAIT_CLR && state_nxt == ST_GAP)
            gap_cnt <= ie_gap;
        else if (state == ST_GAP)
            gap_cnt <= gap_cnt - 8'd1;
    end
`endif

    always_comb begin
        x_ie_value = '0;
        if (regs_idx == L2IE_IDX) begin
            x_ie_value[L2IE_EN_LSB +: L2IE_EN_W] = ie_mask;
`ifdef CIU_L2OF_INT_THROTTLE_EN
            x_ie_value[L2IE_GAP_LSB +: L2IE_GAP_W] = ie_gap;
`endif
        end
    end

    always_ff @(posedge smpr_clk or negedge x_fifo_rst_b) begin
        if (!x_fifo_rst_b) begin
            state   <= ST_IDLE;
            int_src <= '0;
        end else begin
            state   <= state_nxt;
            int_src <= src_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        src_nxt   = int_src;
        case (state)
            ST_IDLE: begin
                if (|masked) begin
                    state_nxt = ST_REQ;
                    src_nxt   = masked;
                end
            end
            ST_REQ: begin
                // Accumulate even on the ack cycle so a coincident new cause is not lost.
                src_nxt = int_src | masked;
                if (int_ack)
                    state_nxt = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                if ((x_l2of_int & int_src) == 4'd0) begin
                    src_nxt = '0;
`ifdef CIU_L2OF_INT_THROTTLE_EN
                    state_nxt = (ie_gap != 8'd0) ? ST_GAP : ST_IDLE;
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef CIU_L2OF_INT_THROTTLE_EN
            ST_GAP: begin
                if (gap_cnt == 8'd1)
                    state_nxt = ST_IDLE;
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
                src_nxt   = '0;
            end
        endcase
    end

    assign int_req = (state == ST_REQ);

    assign unused_wdata = ^regs_wdata_final;

endmodule
